// File: rtl/draw_scheduler_if.sv
// Signal bundle between the frame sequencer, the three drawing engines and
// the VGA adapter plot port. The scheduler uses the slave view and its
// environment uses the master view.
//
// Handshake semantics:
//  - frame_tick is a one-cycle request that is accepted only while busy is low.
//  - start[i] is a one-cycle command to engine i.
//  - done[i] is honoured only while grant[i] is high and not in the start cycle.
//  - req_plot[i] is a write strobe that is forwarded only while grant[i] is high.
interface draw_scheduler_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int C_W = 3
) ();
    logic               frame_tick;
    logic [2:0]         phase_en;
    logic [2:0]         start;
    logic [2:0]         done;
    logic [3*X_W-1:0]   req_x;
    logic [3*Y_W-1:0]   req_y;
    logic [3*C_W-1:0]   req_colour;
    logic [2:0]         req_plot;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [C_W-1:0]     colour;
    logic               plot;
    logic [2:0]         grant;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic [2:0]         timeout_err;

    modport slave (
        input  frame_tick, phase_en, done, req_x, req_y, req_colour, req_plot,
        output start, x, y, colour, plot, grant, busy, frame_done, overrun,
               timeout_err
    );

    modport master (
        output frame_tick, phase_en, done, req_x, req_y, req_colour, req_plot,
        input  start, x, y, colour, plot, grant, busy, frame_done, overrun,
               timeout_err
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer and pixel write-port arbiter. Each accepted frame_tick
// runs the enabled engines in order 0 (clear), 1 (tiles), 2 (score), granting
// the single plot port to one engine at a time, with a per-phase timeout.
module draw_scheduler #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             resetn,
    draw_scheduler_if.slave  bus,
    output logic [2:0]       dbg_state_o
);

    // TIMEOUT must be at least 2 so the timeout cannot fire in a start cycle.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [2:0]       en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       terr_q, terr_d;
    logic [2:0]       grant_q;
    logic             fdone_q;
    logic             overrun_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [C_W-1:0]   colour_q;
    logic             plot_q;

    logic [1:0]       cur_idx;
    logic             sel_plot;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_colour;

    function automatic state_t phase_of(input int i);
        case (i)
            0:       return S_P0;
            1:       return S_P1;
            default: return S_P2;
        endcase
    endfunction

    // Lowest enabled phase with index >= lo, or FIN when none remains.
    function automatic state_t next_phase(input logic [2:0] en, input int lo);
        state_t r;
        r = S_FIN;
        for (int j = 2; j >= 0; j--) begin
            if (j >= lo && en[j]) r = phase_of(j);
        end
        return r;
    endfunction

    function automatic logic [2:0] grant_of(input state_t s);
        case (s)
            S_P0:    return 3'b001;
            S_P1:    return 3'b010;
            S_P2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Index of the engine owning the current phase.
    always_comb begin
        cur_idx = 2'd0;
        case (state_q)
            S_P1:    cur_idx = 2'd1;
            S_P2:    cur_idx = 2'd2;
            default: cur_idx = 2'd0;
        endcase
    end

    // Next-state logic: phase sequencing, timeout counting and error capture.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        en_d    = en_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    en_d    = bus.phase_en;
                    terr_d  = 3'b000;
                    state_d = next_phase(bus.phase_en, 0);
                end
            end
            S_P0, S_P1, S_P2: begin
                // Saturate so a stuck phase never wraps back to zero.
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                if (!first_q) begin
                    // done takes priority over a coincident timeout.
                    if (bus.done[cur_idx]) begin
                        state_d = next_phase(en_q, int'(cur_idx) + 1);
                    end else if (cnt_q == CNT_LAST) begin
                        terr_d[cur_idx] = 1'b1;
                        state_d = next_phase(en_q, int'(cur_idx) + 1);
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Entering a new phase: flag its start cycle and restart the counter.
        if (state_d != state_q && grant_of(state_d) != 3'b000) begin
            first_d = 1'b1;
            cnt_d   = '0;
        end
    end

    // Control registers; grant is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            en_q      <= 3'b000;
            cnt_q     <= '0;
            terr_q    <= 3'b000;
            grant_q   <= 3'b000;
            fdone_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
            grant_q   <= grant_of(state_d);
            fdone_q   <= (state_q == S_FIN);
            overrun_q <= bus.frame_tick && (state_q != S_IDLE);
        end
    end

    // Select the granted engine's pixel; ungranted strobes are dropped.
    always_comb begin
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_q[i] && bus.req_plot[i]) begin
                sel_plot   = 1'b1;
                sel_x      = bus.req_x[i*X_W +: X_W];
                sel_y      = bus.req_y[i*Y_W +: Y_W];
                sel_colour = bus.req_colour[i*C_W +: C_W];
            end
        end
    end

    // Registered pixel port; coordinates hold while no pixel is written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= sel_plot;
            if (sel_plot) begin
                x_q      <= sel_x;
                y_q      <= sel_y;
                colour_q <= sel_colour;
            end
        end
    end

    assign bus.start       = first_q ? grant_q : 3'b000;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = fdone_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = terr_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.plot        = plot_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed frames with hand-computed event lists.
// Every cycle with start/frame_done/overrun/plot activity forms one event that
// is compared against the expected queue; rel counts cycles since the edge
// that accepted the frame_tick.
module tb_draw_scheduler;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int C_W     = 3;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    draw_scheduler_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();
    logic [2:0] dbg_state;

    draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    logic [2:0]  eng_done = 3'b000;
    logic [2:0]  extra_done = 3'b000;
    logic [2:0]  forbid = 3'b000;
    logic        mark = 1'b0;
    int          lat [3];
    int          cd [3];
    int          total = 0;
    int          bad = 0;
    int          rel = 0;
    logic [63:0] exp_q [$];

    assign bus.done = eng_done | extra_done;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t rel=%0d", name, act, expv, $time, rel);
        end
    endtask

    function automatic logic [63:0] mk_ev(input int r, input logic [2:0] st, input logic [2:0] g,
                                          input logic b, input logic fd, input logic ov, input logic pl,
                                          input int px, input int py, input int pc, input logic [2:0] te);
        logic [7:0]     r8;
        logic [X_W-1:0] x9;
        logic [Y_W-1:0] y8;
        logic [C_W-1:0] c3;
        r8 = 8'(r);
        x9 = X_W'(px);
        y8 = Y_W'(py);
        c3 = C_W'(pc);
        return 64'({r8, st, g, b, fd, ov, pl, x9, y8, c3, te});
    endfunction

    task automatic ev(input int r, input logic [2:0] st, input logic [2:0] g, input logic b,
                      input logic fd, input logic ov, input logic pl,
                      input int px, input int py, input int pc, input logic [2:0] te);
        exp_q.push_back(mk_ev(r, st, g, b, fd, ov, pl, px, py, pc, te));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        bus.frame_tick = 1'b1;
        mark = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        mark = 1'b0;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
    endtask

    task automatic set_pix(input int e, input int px, input int py, input int pc);
        bus.req_plot[e] = 1'b1;
        bus.req_x[e*X_W +: X_W] = X_W'(px);
        bus.req_y[e*Y_W +: Y_W] = Y_W'(py);
        bus.req_colour[e*C_W +: C_W] = C_W'(pc);
    endtask

    task automatic clr_pix();
        bus.req_plot = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_colour = '0;
    endtask

    task automatic check_drained(input string name);
        check_eq(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_quiet(input string name);
        check_eq({name, "_ctrl"}, 64'({bus.start, bus.grant, bus.busy, bus.frame_done,
                                       bus.overrun, bus.timeout_err}), 64'd0);
        check_eq({name, "_pix"}, 64'({bus.plot, bus.x, bus.y, bus.colour}), 64'd0);
        check_eq({name, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // Full frame, all engines, done 5/10/3 cycles after their start pulses.
    task automatic run_full_frame(input string name);
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(7,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(18, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(23, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        set_lat(5, 10, 3);
        bus.phase_en = 3'b111;
        do_tick();
        repeat (30) step();
        check_drained(name);
    endtask

    // Engine model: done[i] pulses lat[i] cycles after start[i]; lat 0 never finishes.
    initial begin
        for (int i = 0; i < 3; i++) cd[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!resetn) begin
                    cd[i] = 0;
                    eng_done[i] = 1'b0;
                end else begin
                    eng_done[i] = 1'b0;
                    if (cd[i] > 0) begin
                        cd[i]--;
                        if (cd[i] == 0) eng_done[i] = 1'b1;
                    end
                    if (bus.start[i] && lat[i] > 0) cd[i] = lat[i];
                end
            end
        end
    end

    // Monitor: grant invariants every cycle, event comparison on activity.
    initial begin
        logic [63:0] act;
        logic [63:0] expv;
        forever begin
            @(negedge clk);
            if (bus.frame_tick && mark) rel = 0;
            else rel++;
            if (resetn) begin
                check_eq("grant_onehot", 64'($onehot0(bus.grant)), 64'd1);
                if (forbid != 3'b000) check_eq("grant_forbidden", 64'(bus.grant & forbid), 64'd0);
            end
            if (bus.start != 3'b000 || bus.frame_done || bus.overrun || bus.plot) begin
                act = mk_ev(rel, bus.start, bus.grant, bus.busy, bus.frame_done, bus.overrun, bus.plot,
                            bus.plot ? int'(bus.x) : 0, bus.plot ? int'(bus.y) : 0,
                            bus.plot ? int'(bus.colour) : 0, bus.timeout_err);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", act, 64'd0);
                end else begin
                    expv = exp_q.pop_front();
                    check_eq("event", act, expv);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        bus.frame_tick = 1'b0;
        bus.phase_en = 3'b000;
        clr_pix();
        set_lat(0, 0, 0);

        resetn = 1'b0;
        repeat (3) step();
        check_quiet("in_reset");
        resetn = 1'b1;
        repeat (2) step();
        check_quiet("after_reset");

        // All three engines in order.
        run_full_frame("t1_full_frame");

        // Engines 0 and 2 only; engine 1 must never be granted.
        forbid = 3'b010;
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(7,  3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(12, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        set_lat(5, 10, 3);
        bus.phase_en = 3'b101;
        do_tick();
        repeat (20) step();
        check_drained("t2_skip_phase1");
        forbid = 3'b000;

        // Nothing enabled: straight to FIN.
        ev(2, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        bus.phase_en = 3'b000;
        do_tick();
        repeat (6) step();
        check_drained("t2_empty_frame");

        // Pixel mux: only the granted engine's strobes get through.
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(4,  3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 10, 20, 4, 3'b000);
        ev(7,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 7, 8, 6, 3'b000);
        ev(10, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 120, 5, 7, 3'b000);
        ev(14, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 300, 200, 5, 3'b000);
        ev(15, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        set_lat(5, 6, 0);
        bus.phase_en = 3'b011;
        do_tick();
        repeat (2) step();
        set_pix(0, 10, 20, 4);
        set_pix(1, 1, 2, 3);
        step(); clr_pix();
        repeat (2) step();
        set_pix(0, 7, 8, 6);
        set_pix(1, 50, 60, 2);
        step(); clr_pix();
        repeat (2) step();
        set_pix(1, 120, 5, 7);
        set_pix(0, 0, 0, 0);
        step(); clr_pix();
        repeat (3) step();
        set_pix(1, 300, 200, 5);
        step(); clr_pix();
        set_pix(1, 9, 9, 1);
        step(); clr_pix();
        repeat (10) step();
        check_drained("t3_pixel_mux");

        // Engine 1 hangs: timeout after 16 cycles, sticky error until next frame.
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(7,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(23, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b010);
        ev(28, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b010);
        set_lat(5, 0, 3);
        bus.phase_en = 3'b111;
        do_tick();
        repeat (34) step();
        check_eq("t4_timeout_err_sticky", 64'(bus.timeout_err), 64'h2);
        check_drained("t4_timeout_frame");
        ev(2, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        bus.phase_en = 3'b000;
        do_tick();
        repeat (6) step();
        check_eq("t4_timeout_err_cleared", 64'(bus.timeout_err), 64'h0);
        check_drained("t4_clear_frame");

        // Overrun ticks, early done[1] and foreign done[0] do not disturb the frame.
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(7,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(11, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        ev(18, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(23, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        set_lat(5, 10, 3);
        bus.phase_en = 3'b111;
        do_tick();
        repeat (6) step();
        extra_done = 3'b010;
        step(); extra_done = 3'b000;
        repeat (2) step();
        bus.frame_tick = 1'b1;
        step(); bus.frame_tick = 1'b0;
        step(); extra_done = 3'b001;
        step(); extra_done = 3'b000;
        repeat (9) step();
        bus.frame_tick = 1'b1;
        step(); bus.frame_tick = 1'b0;
        repeat (8) step();
        check_drained("t5_overrun_ignored_done");

        // Reset in the middle of phase 1 aborts without frame_done.
        ev(1,  3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(7,  3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);
        ev(10, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 33, 44, 5, 3'b000);
        set_lat(5, 10, 3);
        bus.phase_en = 3'b111;
        do_tick();
        repeat (8) step();
        set_pix(1, 33, 44, 5);
        step(); resetn = 1'b0;
        step(); clr_pix();
        check_quiet("t6_mid_frame_reset");
        step(); resetn = 1'b1;
        repeat (15) step();
        check_drained("t6_abort");
        run_full_frame("t6_frame_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
